// File: rtl/fetch_pkg.sv
// Shared constants and elaboration helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched instruction/PC pairs; flush empties it at the next edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      used;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (used != '0);
  assign do_push = push && (used != (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      used <= used + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign rdata = store[rd_ptr];
  assign valid = (used != '0);
  assign count = used;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: sync-read instruction memory feeding a credit-controlled queue, with
// redirect, halt-word detection, debug memory writes and single-step fetch.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       QDEPTH    = 4,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEFAULT_HALT_WORD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic                    i_program_memory_write,
  input  logic [ADDR_W-1:0]       i_address_write,
  input  logic [DATA_W-1:0]       i_instruction_write,
  input  logic                    i_taken,
  input  logic [PC_W-1:0]         i_branch_address,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_instruction,
  output logic [PC_W-1:0]         o_pc,
  output logic                    o_stop_pipe,
  output logic [clog2(QDEPTH):0]  o_count
);

  localparam int unsigned CW = clog2(QDEPTH) + 1;
  localparam int unsigned QW = DATA_W + PC_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   inflight_pc;
  logic              inflight;
  fetch_state_e      state;
  fetch_state_e      state_next;

  logic              halt_arriving;
  logic              credit_ok;
  logic              step_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic [QW-1:0]     head;
  logic              q_valid;
  logic [CW-1:0]     q_count;

  assign pc_inc        = pc + PC_W'(PC_INC);
  assign halt_arriving = inflight && (rdata == HALT_WORD);
  // The in-flight read already owns a queue slot, so count it against the depth.
  assign credit_ok     = ({1'b0, q_count} + {{CW{1'b0}}, inflight}) < (CW+1)'(QDEPTH);
  assign step_ok       = !i_step_mode || i_step;
  assign issue         = (state == FETCH_RUN) && !i_program_memory_write && !i_taken &&
                         credit_ok && step_ok && !halt_arriving;
  assign push          = inflight && !i_taken;
  assign pop           = q_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst && i_program_memory_write) mem[i_address_write] <= i_instruction_write;
  end

  always_ff @(posedge clk) begin
    if (issue) rdata <= mem[pc[ADDR_W+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc_inc;
      if (i_taken)    pc <= i_branch_address;
      else if (issue) pc <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_taken)            state_next = FETCH_RUN;
    else if (halt_arriving) state_next = FETCH_HALTED;
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (i_taken),
    .push  (push),
    .pop   (pop),
    .wdata ({rdata, inflight_pc}),
    .rdata (head),
    .valid (q_valid),
    .count (q_count)
  );

  assign o_valid       = q_valid;
  assign o_count       = q_count;
  assign o_instruction = q_valid ? head[QW-1:PC_W] : '0;
  assign o_pc          = q_valid ? head[PC_W-1:0] : '0;
  assign o_stop_pipe   = q_valid && (head[QW-1:PC_W] == HALT_WORD);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized and directed checks of fetch_queue_stage against a queue-based reference model.
module tb_fetch_queue_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, step_mode, step, wr, taken, ready;
  logic [7:0]  wa;
  logic [31:0] wd, ba;
  logic        valid, stop;
  logic [31:0] instr, pcv;
  logic [2:0]  count;

  fetch_queue_stage dut (
    .clk(clk), .rst(rst), .i_step_mode(step_mode), .i_step(step),
    .i_program_memory_write(wr), .i_address_write(wa), .i_instruction_write(wd),
    .i_taken(taken), .i_branch_address(ba), .o_valid(valid), .i_ready(ready),
    .o_instruction(instr), .o_pc(pcv), .o_stop_pipe(stop), .o_count(count)
  );

  logic        s_rst, s_sm, s_step, s_wr, s_tk, s_ready;
  logic [7:0]  s_wa;
  logic [31:0] s_wd;
  logic [15:0] s_ba, s_pc;
  logic        s_valid, s_stop;
  logic [31:0] s_instr;
  logic [2:0]  s_count;

  fetch_queue_stage #(.PC_W(16)) dut16 (
    .clk(clk), .rst(s_rst), .i_step_mode(s_sm), .i_step(s_step),
    .i_program_memory_write(s_wr), .i_address_write(s_wa), .i_instruction_write(s_wd),
    .i_taken(s_tk), .i_branch_address(s_ba), .o_valid(s_valid), .i_ready(s_ready),
    .o_instruction(s_instr), .o_pc(s_pc), .o_stop_pipe(s_stop), .o_count(s_count)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of {instruction, fetch address + 4} plus one pending read.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mmem [256];
  logic [31:0] mpc = 32'h0;
  bit          mpend = 1'b0;
  logic [31:0] mpend_data = 32'h0;
  logic [31:0] mpend_pc = 32'h0;
  bit          mhalted = 1'b0;

  logic [31:0] heads[$];
  logic [31:0] head_pcs[$];
  bit          head_stop[$];

  task automatic compare_outputs();
    if (mq.size() > 0) begin
      check("valid", valid, 1);
      check("instr", instr, mq[0].instr);
      check("pc", pcv, mq[0].pc);
      check("stop", stop, mq[0].instr == HALT);
    end else begin
      check("valid", valid, 0);
      check("instr", instr, 0);
      check("pc", pcv, 0);
      check("stop", stop, 0);
    end
    check("count", count, mq.size());
  endtask

  task automatic model_step(input bit r, input bit sm, input bit st, input bit w,
                            input logic [7:0] a, input logic [31:0] d,
                            input bit tk, input logic [31:0] b, input bit rd);
    bit arriving;
    bit halt_arr;
    bit issue;
    arriving = mpend;
    halt_arr = arriving && (mpend_data == HALT);
    issue = !mhalted && !w && !tk && (mq.size() + int'(mpend) < 4) && (!sm || st) && !halt_arr;
    if (r) begin
      mq.delete();
      mpc = 32'h0;
      mpend = 1'b0;
      mhalted = 1'b0;
      return;
    end
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (tk) begin
      mq.delete();
      mhalted = 1'b0;
    end else if (arriving) begin
      mq.push_back('{mpend_data, mpend_pc});
      if (halt_arr) mhalted = 1'b1;
    end
    mpend = issue;
    if (issue) begin
      mpend_data = mmem[(mpc >> 2) % 256];
      mpend_pc = mpc + 32'd4;
      mpc = mpc + 32'd4;
    end
    if (tk) mpc = b;
    if (w) mmem[a] = d;
  endtask

  task automatic cyc(input bit r, input bit sm, input bit st, input bit w,
                     input logic [7:0] a, input logic [31:0] d,
                     input bit tk, input logic [31:0] b, input bit rd);
    compare_outputs();
    if (valid && rd && !r) begin
      heads.push_back(instr);
      head_pcs.push_back(pcv);
      head_stop.push_back(stop);
    end
    rst = r; step_mode = sm; step = st; wr = w; wa = a; wd = d; taken = tk; ba = b; ready = rd;
    model_step(r, sm, st, w, a, d, tk, b, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit sm, input bit rd, input int n);
    for (int k = 0; k < n; k++) cyc(0, sm, 0, 0, 8'h0, 32'h0, 0, 32'h0, rd);
  endtask

  task automatic check_prog(input string tag);
    logic [31:0] prog [4];
    prog = '{32'h11, 32'h22, 32'h33, HALT};
    check({tag, "_n"}, heads.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_instr"}, heads[k], prog[k]);
      check({tag, "_pc"}, head_pcs[k], 32'(4 * (k + 1)));
      check({tag, "_stop"}, head_stop[k], k == 3);
    end
  endtask

  initial begin
    logic [31:0] wv;
    bit          sm_blk;
    int          got;
    logic [31:0] g_instr [2];
    logic [15:0] g_pc [2];
    bit          g_stop;

    rst = 1; step_mode = 0; step = 0; wr = 0; wa = '0; wd = '0; taken = 0; ba = '0; ready = 0;
    s_rst = 1; s_sm = 1; s_step = 0; s_wr = 0; s_wa = '0; s_wd = '0; s_tk = 0; s_ba = '0; s_ready = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);

    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       wv = 32'h11;
        1:       wv = 32'h22;
        2:       wv = 32'h33;
        3:       wv = HALT;
        16:      wv = 32'h1616_1616;
        default: wv = $urandom & 32'h7FFF_FFFF;
      endcase
      cyc(0, 0, 0, 1, i[7:0], wv, 0, 32'h0, 0);
    end

    // Straight-line program ending in HALT
    heads.delete(); head_pcs.delete(); head_stop.delete();
    run(0, 1, 12);
    check_prog("r23");

    // Backpressure saturates the queue
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    run(0, 0, 10);
    check("r24_full", count, 4);
    heads.delete(); head_pcs.delete(); head_stop.delete();
    run(0, 1, 8);
    check_prog("r24");

    // Redirect flushes a full queue
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    run(0, 0, 6);
    cyc(0, 0, 0, 0, 8'h0, 32'h0, 1, 32'h40, 0);
    check("r25_flush", valid, 0);
    heads.delete(); head_pcs.delete(); head_stop.delete();
    run(0, 1, 6);
    check("r25_instr", heads[0], 32'h1616_1616);
    check("r25_pc", head_pcs[0], 32'h44);

    // Single-step fetch
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 1, 1, 0, 8'h0, 32'h0, 0, 32'h0, 0);
      run(1, 0, 4);
    end
    check("r26_cnt", count, 3);
    heads.delete(); head_pcs.delete(); head_stop.delete();
    cyc(0, 1, 1, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    run(1, 1, 8);
    check_prog("r26");

    // Reset during an in-flight read
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    run(0, 0, 3);
    check("r27_cnt", count, 2);
    cyc(1, 0, 0, 0, 8'h0, 32'h0, 0, 32'h0, 0);
    check("r27_valid", valid, 0);
    check("r27_count", count, 0);
    heads.delete(); head_pcs.delete(); head_stop.delete();
    run(0, 1, 8);
    check_prog("r27");

    sm_blk = 0;
    for (int n = 0; n < 1500; n++) begin
      bit r, w, tk;
      if (n % 100 == 0) sm_blk = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 19) == 0);
      wv = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      cyc(r, sm_blk, 1'($urandom_range(0, 1)), w, 8'($urandom), wv, tk, $urandom,
          $urandom_range(0, 9) < 7);
    end

    // 16-bit PC wrap on a second instance
    check("w16_cnt_rst", s_count, 0);
    s_rst = 0;
    s_wr = 1; s_wa = 8'hFF; s_wd = 32'hAAAA_0001;
    @(posedge clk); #1;
    s_wa = 8'h00; s_wd = 32'hBBBB_0002;
    @(posedge clk); #1;
    s_wr = 0; s_tk = 1; s_ba = 16'hFFFC;
    @(posedge clk); #1;
    s_tk = 0; s_sm = 0; s_ready = 1;
    got = 0;
    g_stop = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      if (s_valid) begin
        g_instr[got] = s_instr;
        g_pc[got] = s_pc;
        if (got == 0) g_stop = s_stop;
        got++;
      end
      @(posedge clk); #1;
    end
    check("w16_heads", got, 2);
    check("w16_instr0", g_instr[0], 32'hAAAA_0001);
    check("w16_pc0", g_pc[0], 16'h0000);
    check("w16_stop0", g_stop, 0);
    check("w16_instr1", g_instr[1], 32'hBBBB_0002);
    check("w16_pc1", g_pc[1], 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
